rvfi_retire_checker: RTL

Parametrised synthesizable RVFI retirement checker that sits beside a core under formal or simulation verification, alongside the per-instruction spec checkers. It generalises the single-retirement check-cycle harness to NRET retirement lanes and NBUS bus channels. It tracks a saturating check-cycle counter and checks instruction order and PC continuity across lanes and cycles. It also checks bus ack legality and, optionally, bus timeouts, raising sticky error flags that properties or testbenches consume.

---
 rtl/rvfi_retire_checker_if.sv | 25 ++
 rtl/rvfi_retire_checker.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_checker_if.sv
// RVFI retirement lanes and bus handshake bundle observed by rvfi_retire_checker.
// The core side (or a bench) drives through master; the checker samples through slave.
interface rvfi_retire_checker_if #(
  parameter int NRET = 1,
  parameter int XLEN = 32,
  parameter int NBUS = 2
);
  logic [NRET-1:0]      i_rvfi_valid;
  logic [64*NRET-1:0]   i_rvfi_order;
  logic [XLEN*NRET-1:0] i_rvfi_pc_rdata;
  logic [XLEN*NRET-1:0] i_rvfi_pc_wdata;
  logic [NRET-1:0]      i_rvfi_trap;
  logic [NBUS-1:0]      i_bus_cyc;
  logic [NBUS-1:0]      i_bus_ack;

  modport master (
    output i_rvfi_valid, i_rvfi_order, i_rvfi_pc_rdata, i_rvfi_pc_wdata, i_rvfi_trap,
    output i_bus_cyc, i_bus_ack
  );

  modport slave (
    input i_rvfi_valid, i_rvfi_order, i_rvfi_pc_rdata, i_rvfi_pc_wdata, i_rvfi_trap,
    input i_bus_cyc, i_bus_ack
  );
endinterface

// File: rtl/rvfi_retire_checker.sv
// Multi-lane RVFI retirement checker: check-cycle counter, order/PC continuity, bus ack legality.
// Optional per-bus stall timeout enabled by defining RVFI_BUS_TIMEOUT_EN.
module rvfi_retire_checker #(
  parameter int NRET        = 1,
  parameter int XLEN        = 32,
  parameter int NBUS        = 2,
  parameter int CHECK_CYCLE = 20,
  parameter int TIMEOUT_W   = 3
) (
  input  logic                clk,
  input  logic                i_rst,
  rvfi_retire_checker_if.slave rvfi_if,
  output logic                o_check,
  output logic [31:0]         o_retired,
  output logic                o_err_order,
  output logic                o_err_pc,
  output logic [NBUS-1:0]     o_err_ack,
  output logic [NBUS-1:0]     o_err_timeout,
  output logic                o_err_any
);

  localparam int         CNT_W     = $clog2(NRET + 1);
  localparam logic [6:0] CHECK_VAL = 7'(CHECK_CYCLE);

  logic [6:0]      r_cycle;
  logic [31:0]     r_retired;
  logic [63:0]     r_exp_order;
  logic            r_have_prev;
  logic [XLEN-1:0] r_prev_pc;
  logic            r_prev_trap;
  logic            r_err_order;
  logic            r_err_pc;
  logic [NBUS-1:0] r_err_ack;
  logic [NBUS-1:0] w_err_timeout;

  logic            w_err_order;
  logic            w_err_pc;
  logic            w_gap;
  logic            w_have;
  logic [XLEN-1:0] w_pc;
  logic            w_trap;
  logic [CNT_W-1:0] w_popcnt;
  logic [32:0]     w_retired_sum;
  logic [NBUS-1:0] w_ack_err;

  // Lanes are walked in order so each lane's PC check sees the nearest earlier
  // retirement, either from this cycle or the one stored from a previous cycle.
  // NOTE: w_have/w_pc/w_trap are reassigned per lane with blocking '=' on purpose:
  // the chain must observe the update from the lane just processed in the same pass.
  always_comb begin
    w_err_order = 1'b0;
    w_err_pc    = 1'b0;
    w_gap       = 1'b0;
    w_have      = r_have_prev;
    w_pc        = r_prev_pc;
    w_trap      = r_prev_trap;
    w_popcnt    = '0;
    for (int k = 0; k < NRET; k++) begin
      if (rvfi_if.i_rvfi_valid[k]) begin
        if (w_gap) w_err_order = 1'b1;
        if (rvfi_if.i_rvfi_order[k*64 +: 64] != r_exp_order + 64'(k)) w_err_order = 1'b1;
        if (w_have && !w_trap && (rvfi_if.i_rvfi_pc_rdata[k*XLEN +: XLEN] != w_pc))
          w_err_pc = 1'b1;
        w_have   = 1'b1;
        w_pc     = rvfi_if.i_rvfi_pc_wdata[k*XLEN +: XLEN];
        w_trap   = rvfi_if.i_rvfi_trap[k];
        w_popcnt = w_popcnt + CNT_W'(1);
      end else begin
        w_gap = 1'b1;
      end
    end
  end

  assign w_retired_sum = {1'b0, r_retired} + 33'(w_popcnt);
  assign w_ack_err     = rvfi_if.i_bus_ack & ~rvfi_if.i_bus_cyc;

  // NOTE: reset is synchronous; i_rst is only seen at a clock edge, never asynchronously.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cycle     <= '0;
      r_retired   <= '0;
      r_exp_order <= '0;
      r_have_prev <= 1'b0;
      r_prev_pc   <= '0;
      r_prev_trap <= 1'b0;
      r_err_order <= 1'b0;
      r_err_pc    <= 1'b0;
    end else begin
      if (r_cycle != CHECK_VAL) r_cycle <= r_cycle + 7'd1;
      r_retired   <= w_retired_sum[32] ? 32'hFFFF_FFFF : w_retired_sum[31:0];
      r_exp_order <= r_exp_order + 64'(w_popcnt);
      r_have_prev <= w_have;
      r_prev_pc   <= w_pc;
      r_prev_trap <= w_trap;
      r_err_order <= r_err_order | w_err_order;
      r_err_pc    <= r_err_pc | w_err_pc;
    end
  end

  // An illegal ack is still recorded on the reset cycle itself.
  always_ff @(posedge clk) begin
    if (i_rst) r_err_ack <= w_ack_err;
    else       r_err_ack <= r_err_ack | w_ack_err;
  end

`ifdef RVFI_BUS_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_stall [NBUS];
  logic [NBUS-1:0]      r_err_timeout;
  logic [NBUS-1:0]      w_stall;

  assign w_stall = rvfi_if.i_bus_cyc & ~rvfi_if.i_bus_ack;

  // Counter saturates at all-ones; a further stall cycle flags the timeout.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_err_timeout <= '0;
      for (int b = 0; b < NBUS; b++) r_stall[b] <= '0;
    end else begin
      for (int b = 0; b < NBUS; b++) begin
        if (w_stall[b]) begin
          if (r_stall[b] != '1) r_stall[b] <= r_stall[b] + TIMEOUT_W'(1);
          else                  r_err_timeout[b] <= 1'b1;
        end else begin
          r_stall[b] <= '0;
        end
      end
    end
  end

  assign w_err_timeout = r_err_timeout;
`else
  assign w_err_timeout = '0;
`endif

  assign o_check       = (r_cycle == CHECK_VAL);
  assign o_retired     = r_retired;
  assign o_err_order   = r_err_order;
  assign o_err_pc      = r_err_pc;
  assign o_err_ack     = r_err_ack;
  assign o_err_timeout = w_err_timeout;
  assign o_err_any     = r_err_order | r_err_pc | (|r_err_ack) | (|w_err_timeout);

endmodule
